// File: rtl/mem_copy64.sv
// mem_copy64: word-by-word RAM-to-RAM copy engine.
// Each word costs one READ cycle (capture ram_out) and one WRITE cycle (store it).
// Source and destination addresses wrap modulo the RAM size. The copy runs in
// ascending order, so overlapping ranges see earlier writes of the same copy.
module mem_copy64 #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);

  localparam int unsigned   Words  = 1 << ADDR_W;
  localparam logic [ADDR_W:0] MaxLen = Words[ADDR_W:0];
  localparam logic [ADDR_W:0] One    = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_i;
  logic [ADDR_W:0]     r_words;
  logic [DATA_W-1:0]   r_data;
  logic                r_busy;
  logic                r_done;

  logic [ADDR_W:0]     w_len_sat;
  logic [ADDR_W:0]     w_i_next;

  // Requests longer than the RAM are clamped to one full pass.
  assign w_len_sat = (len > MaxLen) ? MaxLen : len;
  assign w_i_next  = r_i + One;

  // Control FSM; busy and done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_i     <= '0;
      r_words <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (start) begin
            r_src   <= src;
            r_dst   <= dst;
            r_len   <= w_len_sat;
            r_i     <= '0;
            r_words <= '0;
            if (w_len_sat == '0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state <= StRead;
              r_busy  <= 1'b1;
            end
          end
        end
        StRead: begin
          r_data  <= ram_out;
          r_state <= StWrite;
        end
        StWrite: begin
          r_i     <= w_i_next;
          r_words <= r_words + One;
          if (w_i_next == r_len) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= StRead;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  // RAM port decode; the write enable is gated by reset so an abort never writes.
  always_comb begin
    ram_addr = '0;
    ram_in   = '0;
    ram_load = 1'b0;
    unique case (r_state)
      StRead: begin
        ram_addr = r_src + r_i[ADDR_W-1:0];
      end
      StWrite: begin
        ram_addr = r_dst + r_i[ADDR_W-1:0];
        ram_in   = r_data;
        ram_load = ~reset;
      end
      default: begin
      end
    endcase
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign words_done = r_words;

endmodule

// File: tb/tb_mem_copy64.sv
// Directed bench for mem_copy64 with a behavioural 64x16 RAM.
module tb_mem_copy64;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  src;
  logic [5:0]  dst;
  logic [6:0]  len;
  logic        busy;
  logic        done;
  logic [6:0]  words_done;
  logic [5:0]  ram_addr;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [15:0] ram_out;

  logic [15:0] mem [0:63];
  logic        tb_we;
  logic [5:0]  tb_wa;
  logic [15:0] tb_wd;
  int          wr_cnt;
  int          checks;
  int          errors;
  int          cyc;

  mem_copy64 #(.ADDR_W(6), .DATA_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src        (src),
    .dst        (dst),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .ram_addr   (ram_addr),
    .ram_in     (ram_in),
    .ram_load   (ram_load),
    .ram_out    (ram_out)
  );

  always #5 clk = ~clk;

  assign ram_out = mem[ram_addr];

  // RAM model: DUT write port has priority over the bench preload port.
  always @(posedge clk) begin
    if (ram_load) begin
      mem[ram_addr] <= ram_in;
      wr_cnt <= wr_cnt + 1;
    end else if (tb_we) begin
      mem[tb_wa] <= tb_wd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [5:0] a, input logic [15:0] d);
    tb_wa = a;
    tb_wd = d;
    tb_we = 1'b1;
    tick();
    tb_we = 1'b0;
  endtask

  // Accept a copy and count cycles from the accepting edge to the done cycle.
  task automatic run(input logic [5:0] s, input logic [5:0] d, input logic [6:0] l,
                     output int c);
    wr_cnt = 0;
    src = s;
    dst = d;
    len = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    while (!done && c < 300) begin
      tick();
      c++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wr_cnt = 0;
    tb_we  = 1'b0;
    tb_wa  = '0;
    tb_wd  = '0;
    src    = '0;
    dst    = '0;
    len    = '0;
    // Reset together with start: reset must win.
    reset  = 1'b1;
    start  = 1'b1;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_words", {25'd0, words_done}, 32'd0);
    chk("rst_addr", {26'd0, ram_addr}, 32'd0);
    chk("rst_in", {16'd0, ram_in}, 32'd0);
    chk("rst_load", {31'd0, ram_load}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("rst_start_ignored", {31'd0, busy}, 32'd0);

    for (int a = 0; a < 64; a++) poke(a[5:0], 16'h0000);

    // Basic copy 4..6 -> 40..42.
    poke(6'd4, 16'h1111);
    poke(6'd5, 16'h2222);
    poke(6'd6, 16'h3333);
    run(6'd4, 6'd40, 7'd3, cyc);
    chk("basic_lat", cyc, 32'd7);
    chk("basic_words", {25'd0, words_done}, 32'd3);
    chk("basic_wr", wr_cnt, 32'd3);
    chk("basic_m40", {16'd0, mem[40]}, 32'h1111);
    chk("basic_m41", {16'd0, mem[41]}, 32'h2222);
    chk("basic_m42", {16'd0, mem[42]}, 32'h3333);
    tick();
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("words_hold", {25'd0, words_done}, 32'd3);
    chk("idle_addr", {26'd0, ram_addr}, 32'd0);

    // Source wraps 62,63,0,1.
    poke(6'd62, 16'hA062);
    poke(6'd63, 16'hA063);
    poke(6'd0,  16'hA000);
    poke(6'd1,  16'hA001);
    run(6'd62, 6'd10, 7'd4, cyc);
    chk("wrap_lat", cyc, 32'd9);
    chk("wrap_m10", {16'd0, mem[10]}, 32'hA062);
    chk("wrap_m11", {16'd0, mem[11]}, 32'hA063);
    chk("wrap_m12", {16'd0, mem[12]}, 32'hA000);
    chk("wrap_m13", {16'd0, mem[13]}, 32'hA001);
    tick();

    // Zero-length copy.
    run(6'd4, 6'd50, 7'd0, cyc);
    chk("zero_lat", cyc, 32'd1);
    chk("zero_wr", wr_cnt, 32'd0);
    chk("zero_words", {25'd0, words_done}, 32'd0);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    tick();

    // Saturating length: full in-place pass.
    run(6'd0, 6'd0, 7'd100, cyc);
    chk("sat_lat", cyc, 32'd129);
    chk("sat_words", {25'd0, words_done}, 32'd64);
    chk("sat_wr", wr_cnt, 32'd64);
    chk("sat_m40", {16'd0, mem[40]}, 32'h1111);
    tick();

    // Overlap dst=src+1 replicates the first word.
    poke(6'd8,  16'hABCD);
    poke(6'd9,  16'h0009);
    poke(6'd12, 16'h1212);
    run(6'd8, 6'd9, 7'd3, cyc);
    chk("ovl_m9",  {16'd0, mem[9]},  32'hABCD);
    chk("ovl_m10", {16'd0, mem[10]}, 32'hABCD);
    chk("ovl_m11", {16'd0, mem[11]}, 32'hABCD);
    chk("ovl_m12", {16'd0, mem[12]}, 32'h1212);
    tick();

    // Abort during the second WRITE; a start pulse while busy is ignored.
    for (int a = 0; a < 5; a++) begin
      poke(6'(20 + a), 16'hB000 + 16'(a));
      poke(6'(30 + a), 16'h0000);
    end
    wr_cnt = 0;
    src = 6'd20;
    dst = 6'd30;
    len = 7'd5;
    start = 1'b1;
    tick();
    chk("abort_busy", {31'd0, busy}, 32'd1);
    src = 6'd50;
    tick();
    start = 1'b0;
    chk("abort_w1_load", {31'd0, ram_load}, 32'd1);
    chk("abort_w1_addr", {26'd0, ram_addr}, 32'd30);
    tick();
    chk("abort_r2_addr", {26'd0, ram_addr}, 32'd21);
    tick();
    chk("abort_w2_addr", {26'd0, ram_addr}, 32'd31);
    reset = 1'b1;
    #1;
    chk("abort_load_gated", {31'd0, ram_load}, 32'd0);
    tick();
    reset = 1'b0;
    chk("abort_busy_after", {31'd0, busy}, 32'd0);
    chk("abort_done_after", {31'd0, done}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      if (done) chk("abort_no_done", {31'd0, done}, 32'd0);
      tick();
    end
    chk("abort_wr", wr_cnt, 32'd1);
    chk("abort_m30", {16'd0, mem[30]}, 32'hB000);
    chk("abort_m31", {16'd0, mem[31]}, 32'h0000);
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_copy64.md
MEM_COPY64 -- requirements
Module: mem_copy64

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, giving the word-address width of the attached RAM (64 words).
REQ-002 SHALL have parameter DATA_W, default 16, giving the data word width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a copy; sampled only in IDLE.
REQ-006 SHALL have port src, input, ADDR_W: first source word address.
REQ-007 SHALL have port dst, input, ADDR_W: first destination word address.
REQ-008 SHALL have port len, input, ADDR_W+1: word count; 0..64 is legal, and 65..127 saturates to 64.
REQ-009 SHALL have port busy, output, 1 bit: copy in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port words_done, output, ADDR_W+1: number of words written in the current or last copy.
REQ-012 SHALL have port ram_addr, output, ADDR_W: drives the RAM address.
REQ-013 SHALL have port ram_in, output, DATA_W: drives the RAM write data.
REQ-014 SHALL have port ram_load, output, 1 bit: RAM write enable; the RAM writes on the clk edge while it is high.
REQ-015 SHALL have port ram_out, input, DATA_W: RAM read data, combinationally valid for the current ram_addr.

Function
REQ-016 SHALL implement the FSM states IDLE, READ, WRITE and DONE.
REQ-017 SHALL, in IDLE with start=1 at an edge, latch src, dst and the saturated len, clear words_done, and go to READ; if the latched len is 0 it SHALL go to DONE instead.
REQ-018 SHALL, in READ, drive ram_addr=(src+i) mod 64 and ram_load=0, capture ram_out into the data register at the edge, and then go to WRITE.
REQ-019 SHALL, in WRITE, drive ram_addr=(dst+i) mod 64, ram_in=the data register and ram_load=1; at the edge it SHALL increment i and words_done.
REQ-020 SHALL, at the end of WRITE, go to DONE if i+1 equals len, and otherwise go to READ.
REQ-021 SHALL hold done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-022 SHALL hold busy=1 exactly in the READ and WRITE states.
REQ-023 SHALL give a latency of 2*len+1 cycles from the accepting edge to the done cycle, and 1 cycle when len=0.
REQ-024 SHALL wrap address arithmetic modulo 64 for both src+i and dst+i; no error is raised.
REQ-025 SHALL copy in ascending order, one word at a time; for overlapping ranges a READ SHALL observe all earlier WRITEs of the same copy (for example, dst=src+1 replicates word src).
REQ-026 SHALL ignore start in READ, WRITE and DONE; inputs are not re-sampled until the next IDLE acceptance.
REQ-027 SHALL hold ram_load=0 in IDLE, READ and DONE, and whenever reset=1 (gated combinationally).
REQ-028 SHALL drive ram_addr=0 and ram_in=0 in IDLE and DONE.
REQ-029 SHALL hold words_done at its final value after DONE until the next accepted start.

Reset
REQ-030 SHALL, on an edge with reset=1, set state=IDLE, busy=0, done=0, words_done=0, i=0, the data register to 0 and ram_addr=0, with ram_in=0 and ram_load=0.
REQ-031 SHALL, on reset mid-copy, abort with no further writes and no done pulse; words already written stay in the RAM.
REQ-032 SHALL, when reset and start are high at the same edge, let reset win and not accept the copy.

Verification
REQ-033 SHALL cover: preload RAM[4..6]=0x1111,0x2222,0x3333; start with src=4, dst=40, len=3 -> RAM[40..42] match, done in cycle 7 after acceptance, words_done=3.
REQ-034 SHALL cover: src=62, dst=10, len=4 -> reads 62,63,0,1 and writes 10..13.
REQ-035 SHALL cover: len=0 -> done the next cycle, ram_load never high, words_done=0.
REQ-036 SHALL cover: len=100 -> exactly 64 writes and done after 129 cycles.
REQ-037 SHALL cover: RAM[8]=0xABCD with src=8, dst=9, len=3 -> RAM[9..11]=0xABCD.
REQ-038 SHALL cover: reset asserted during the second WRITE of len=5 -> only 1 word written, busy=0 and done=0 next cycle, and start with a new src pulsed while busy is ignored.
